// File: rtl/mpsoc_wb_spram_arbiter.sv
// Two-master Wishbone arbiter for a shared single-port RAM: round-robin on ties, bursts never split.
// Grant takes one cycle; slave signals are muxed combinationally and a watchdog errors out stalled strobes.
module mpsoc_wb_spram_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic [2*AW-1:0] m_adr_i,
  input  logic [2*DW-1:0] m_dat_i,
  input  logic [7:0]      m_sel_i,
  input  logic [1:0]      m_we_i,
  input  logic [1:0]      m_cyc_i,
  input  logic [1:0]      m_stb_i,
  input  logic [3:0]      m_bte_i,
  input  logic [5:0]      m_cti_i,
  output logic [1:0]      m_ack_o,
  output logic [1:0]      m_err_o,
  output logic [DW-1:0]   m_dat_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [3:0]      s_sel_o,
  output logic            s_we_o,
  output logic [1:0]      s_bte_o,
  output logic [2:0]      s_cti_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      gnt_o
);

  localparam logic [1:0]  IDLE    = 2'd0;
  localparam logic [1:0]  GNT0    = 2'd1;
  localparam logic [1:0]  GNT1    = 2'd2;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] wd_q, wd_d;
  logic        granted;
  logic        idx;
  logic        timeout;

  assign granted = (state_q == GNT0) || (state_q == GNT1);
  assign idx     = (state_q == GNT1);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m_cyc_i == 2'b01)      state_d = GNT0;
        else if (m_cyc_i == 2'b10) state_d = GNT1;
        else if (m_cyc_i == 2'b11) state_d = last_q ? GNT0 : GNT1;
        if (state_d == GNT0)      last_d = 1'b0;
        else if (state_d == GNT1) last_d = 1'b1;
      end
      GNT0:    if (!m_cyc_i[0]) state_d = IDLE;
      GNT1:    if (!m_cyc_i[1]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timeout is decided from the counter and the master strobe only, so a slave whose
  // ack depends combinationally on s_stb_o cannot form a loop through it.
  assign timeout = granted && m_stb_i[idx] && (wd_q == WD_LAST);

  assign s_adr_o = idx ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
  assign s_dat_o = idx ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
  assign s_sel_o = idx ? m_sel_i[7:4]       : m_sel_i[3:0];
  assign s_bte_o = idx ? m_bte_i[3:2]       : m_bte_i[1:0];
  assign s_cti_o = idx ? m_cti_i[5:3]       : m_cti_i[2:0];
  assign s_we_o  = granted && m_we_i[idx];
  assign s_cyc_o = granted && m_cyc_i[idx];
  assign s_stb_o = granted && m_stb_i[idx] && !timeout;

  assign m_dat_o = s_dat_i;
  assign gnt_o   = {state_q == GNT1, state_q == GNT0};
  assign m_ack_o = {(state_q == GNT1) && s_ack_i, (state_q == GNT0) && s_ack_i};
  assign m_err_o = {(state_q == GNT1) && (s_err_i || timeout),
                    (state_q == GNT0) && (s_err_i || timeout)};

  always_comb begin
    wd_d = wd_q;
    if (!granted || (state_d == IDLE) || timeout || s_ack_i || s_err_i) wd_d = 16'd0;
    else if (s_stb_o)                                                   wd_d = wd_q + 16'd1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wd_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule
